// File: rtl/m_ext_pkg.sv
// Shared types and constants for the M-extension datapaths (multiplier/divider).
package m_ext_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [XLEN-1:0] MIN_SINT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when no borrow occurs.
module div_step
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = m_ext_pkg::XLEN
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            borrow;

    always_comb begin
        shifted = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
        // Full-width trial keeps the borrow in the top bit even for the widest partial remainder.
        trial   = {rem_i, quo_i[XLEN-1]} - {2'b00, divisor_i};
        borrow  = trial[XLEN+1];
        rem_o   = borrow ? shifted : trial[XLEN:0];
        quo_o   = {quo_i[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a req/ready handshake.
// One quotient bit per CALC cycle; divide-by-zero and signed overflow bypass the iterations.
module div_seq
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = m_ext_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            signed_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            spec_q, spec_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fin_quo, fin_rem;
    logic            a_neg, b_neg;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        spec_d      = spec_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        a_neg = signed_i & dividend_i[XLEN-1];
        b_neg = signed_i & divisor_i[XLEN-1];

        // Special cases preload their final values and skip the iterations.
        fin_quo = spec_q ? quo_q : step_quo;
        fin_rem = spec_q ? rem_q[XLEN-1:0] : step_rem[XLEN-1:0];
        if (negq_q) fin_quo = -fin_quo;
        if (negr_q) fin_rem = -fin_rem;

        case (state_q)
            S_IDLE: begin
                if (req_i && !abort_i) begin
                    state_d = S_CALC;
                    cnt_d   = CNT_W'(XLEN - 1);
                    rem_d   = '0;
                    quo_d   = a_neg ? -dividend_i : dividend_i;
                    dvs_d   = b_neg ? -divisor_i : divisor_i;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    spec_d  = 1'b0;
                    if (divisor_i == '0) begin
                        spec_d = 1'b1;
                        quo_d  = '1;
                        rem_d  = {1'b0, dividend_i};
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                    end else if (signed_i && dividend_i == MIN_VAL && divisor_i == '1) begin
                        spec_d = 1'b1;
                        quo_d  = MIN_VAL;
                        rem_d  = '0;
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (spec_q || cnt_q == '0) begin
                    state_d     = S_DONE;
                    quotient_d  = fin_quo;
                    remainder_d = fin_rem;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            spec_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            spec_q      <= spec_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule
